// File: rtl/hazard_unit_mc_pkg.sv
// Shared types for the hazard/forwarding controller:
// multi-cycle FSM states, forward-select constants and the stall/flush bundle.
package hazard_unit_mc_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard unit bundle.
// master = datapath side, slave = hazard unit side.
interface hazard_unit_mc_if #(
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 5
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic [REG_W-1:0]         rs_d;
  logic [REG_W-1:0]         rt_d;
  logic [REG_W-1:0]         rs_e;
  logic [REG_W-1:0]         rt_e;
  logic [REG_W-1:0]         write_reg_e;
  logic                     reg_write_e;
  logic                     mem_to_reg_e;
  logic [NUM_FWD*REG_W-1:0] fwd_reg;
  logic [NUM_FWD-1:0]       fwd_we;
  logic                     mc_req_e;
  logic                     branch_taken_m;

  logic                     stall_f;
  logic                     stall_d;
  logic                     stall_e;
  logic                     flush_d;
  logic                     flush_e;
  logic                     flush_m;
  logic [SEL_W-1:0]         fwd_a;
  logic [SEL_W-1:0]         fwd_b;
  logic                     mc_busy;
  logic                     mc_done;

  modport master (
    output rs_d, rt_d, rs_e, rt_e,
    output write_reg_e, reg_write_e, mem_to_reg_e,
    output fwd_reg, fwd_we, mc_req_e, branch_taken_m,
    input  stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m,
    input  fwd_a, fwd_b, mc_busy, mc_done
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e,
    input  write_reg_e, reg_write_e, mem_to_reg_e,
    input  fwd_reg, fwd_we, mc_req_e, branch_taken_m,
    output stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m,
    output fwd_a, fwd_b, mc_busy, mc_done
  );

endinterface

// File: rtl/hazard_unit_mc_fwd_select.sv
// Picks the youngest forwarding source whose dest matches src.
// 0 = register file, k = source k-1; r0 is never forwarded.
module hazard_unit_mc_fwd_select
  import hazard_unit_mc_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 5,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_W-1:0]         src,
  input  logic [NUM_FWD*REG_W-1:0] regs,
  input  logic [NUM_FWD-1:0]       we,
  output logic [SEL_W-1:0]         sel
);

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (we[k] && regs[k*REG_W +: REG_W] == src &&
          src != '0) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller: N-source forwarding, load-use
// bubbles, multi-cycle E occupancy FSM and branch-redirect flush.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 5,
  parameter int MC_LAT  = 4
) (
  input  logic            clk,
  input  logic            reset,
  hazard_unit_mc_if.slave hz
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam logic [7:0] CNT_INIT = 8'(MC_LAT - 2);

  mc_state_t    state;
  logic [7:0]   cnt;
  logic         br_c;
  logic         mc_stall;
  logic         lu;
  logic         lu_hit;
  hazard_ctrl_t ctrl;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;

  hazard_unit_mc_fwd_select #(
    .NUM_FWD (NUM_FWD),
    .REG_W   (REG_W),
    .SEL_W   (SEL_W)
  ) u_fwd_a (
    .src  (hz.rs_e),
    .regs (hz.fwd_reg),
    .we   (hz.fwd_we),
    .sel  (sel_a)
  );

  hazard_unit_mc_fwd_select #(
    .NUM_FWD (NUM_FWD),
    .REG_W   (REG_W),
    .SEL_W   (SEL_W)
  ) u_fwd_b (
    .src  (hz.rt_e),
    .regs (hz.fwd_reg),
    .we   (hz.fwd_we),
    .sel  (sel_b)
  );

  // A taken branch aborts any wrong-path multi-cycle op.
  always_ff @(posedge clk) begin
    if (reset || hz.branch_taken_m) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        MC_IDLE: begin
          if (hz.mc_req_e) begin
            if (MC_LAT == 2) begin
              state <= MC_DONE;
            end else begin
              state <= MC_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        MC_BUSY: begin
          if (cnt == 8'd1) begin
            state <= MC_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        MC_DONE: state <= MC_IDLE;
        default: begin
          state <= MC_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign br_c = !reset && hz.branch_taken_m;

  assign mc_stall = !reset && !hz.branch_taken_m &&
                    ((state == MC_IDLE && hz.mc_req_e) ||
                     state == MC_BUSY);

  assign lu_hit = hz.write_reg_e == hz.rs_d ||
                  hz.write_reg_e == hz.rt_d;

  assign lu = !reset && !hz.branch_taken_m && !mc_stall &&
              hz.mem_to_reg_e && hz.reg_write_e &&
              hz.write_reg_e != '0 && lu_hit;

  // Qualifiers above are mutually exclusive, highest priority first.
  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      reset: begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
        ctrl.flush_m = 1'b1;
      end
      br_c: begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
      mc_stall: begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.flush_m = 1'b1;
      end
      lu: begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign hz.stall_f = ctrl.stall_f;
  assign hz.stall_d = ctrl.stall_d;
  assign hz.stall_e = ctrl.stall_e;
  assign hz.flush_d = ctrl.flush_d;
  assign hz.flush_e = ctrl.flush_e;
  assign hz.flush_m = ctrl.flush_m;
  assign hz.fwd_a   = reset ? SEL_W'(FWD_SEL_RF) : sel_a;
  assign hz.fwd_b   = reset ? SEL_W'(FWD_SEL_RF) : sel_b;
  assign hz.mc_busy = mc_stall;
  assign hz.mc_done = !reset && !hz.branch_taken_m &&
                      state == MC_DONE;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: one DUT at MC_LAT=4,
// one at MC_LAT=2, directed vectors with hand-computed outputs.
module tb_hazard_unit_mc;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] wr_e;
    logic       rw_e;
    logic       m2r_e;
    logic [9:0] freg;
    logic [1:0] fwe;
    logic       mc;
    logic       br;
  } in_t;

  typedef struct {
    string       tag;
    bit          u;
    logic [13:0] x;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  in_t  v;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.NUM_FWD(2), .REG_W(5)) h4 ();
  hazard_unit_mc_if #(.NUM_FWD(2), .REG_W(5)) h2 ();

  hazard_unit_mc #(.NUM_FWD(2), .REG_W(5), .MC_LAT(4)) u4 (
    .clk   (clk),
    .reset (reset),
    .hz    (h4)
  );

  hazard_unit_mc #(.NUM_FWD(2), .REG_W(5), .MC_LAT(2)) u2 (
    .clk   (clk),
    .reset (reset),
    .hz    (h2)
  );

  // {sf,sd,se,fd,fe,fm,fa[1:0],fb[1:0],busy,done}
  function automatic logic [13:0] ex(
    bit sf, bit sd, bit se, bit fd, bit fe, bit fm,
    logic [1:0] fa, logic [1:0] fb, bit busy, bit done);
    return {sf, sd, se, fd, fe, fm, fa, fb, busy, done};
  endfunction

  function automatic logic [13:0] act4();
    return {h4.stall_f, h4.stall_d, h4.stall_e,
            h4.flush_d, h4.flush_e, h4.flush_m,
            h4.fwd_a, h4.fwd_b, h4.mc_busy, h4.mc_done};
  endfunction

  function automatic logic [13:0] act2();
    return {h2.stall_f, h2.stall_d, h2.stall_e,
            h2.flush_d, h2.flush_e, h2.flush_m,
            h2.fwd_a, h2.fwd_b, h2.mc_busy, h2.mc_done};
  endfunction

  task automatic drive4(input in_t i);
    h4.rs_d = i.rs_d; h4.rt_d = i.rt_d;
    h4.rs_e = i.rs_e; h4.rt_e = i.rt_e;
    h4.write_reg_e = i.wr_e;
    h4.reg_write_e = i.rw_e;
    h4.mem_to_reg_e = i.m2r_e;
    h4.fwd_reg = i.freg; h4.fwd_we = i.fwe;
    h4.mc_req_e = i.mc; h4.branch_taken_m = i.br;
  endtask

  task automatic drive2(input in_t i);
    h2.rs_d = i.rs_d; h2.rt_d = i.rt_d;
    h2.rs_e = i.rs_e; h2.rt_e = i.rt_e;
    h2.write_reg_e = i.wr_e;
    h2.reg_write_e = i.rw_e;
    h2.mem_to_reg_e = i.m2r_e;
    h2.fwd_reg = i.freg; h2.fwd_we = i.fwe;
    h2.mc_req_e = i.mc; h2.branch_taken_m = i.br;
  endtask

  // One cycle: apply inputs to DUT u (other idles), queue expectation.
  task automatic cyc(input string tag, input bit u,
                     input in_t i, input logic [13:0] x);
    exp_t e;
    @(posedge clk);
    #1;
    reset = i.rst;
    if (u) begin
      drive2(i);
      drive4('0);
    end else begin
      drive4(i);
      drive2('0);
    end
    e.tag = tag;
    e.u = u;
    e.x = x;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [13:0] a;
      e = sb.pop_front();
      a = e.u ? act2() : act4();
      checks++;
      if (a !== e.x) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", e.tag, a, e.x);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive4('0);
    drive2('0);

    // reset: flushes high, forward suppressed
    v = '0; v.rst = 1; v.rs_e = 5;
    v.freg = {5'd5, 5'd5}; v.fwe = 2'b11;
    cyc("rst4", 0, v, ex(0,0,0,1,1,1,0,0,0,0));
    cyc("rst2", 1, v, ex(0,0,0,1,1,1,0,0,0,0));

    // forwarding
    v = '0; v.rs_e = 5;
    v.freg = {5'd5, 5'd5}; v.fwe = 2'b11;
    cyc("fwd_young", 0, v, ex(0,0,0,0,0,0,1,0,0,0));
    v.fwe = 2'b10;
    cyc("fwd_w", 0, v, ex(0,0,0,0,0,0,2,0,0,0));
    v = '0; v.fwe = 2'b11;
    cyc("fwd_r0", 0, v, ex(0,0,0,0,0,0,0,0,0,0));
    v = '0; v.rs_e = 9; v.rt_e = 3;
    v.freg = {5'd9, 5'd3}; v.fwe = 2'b11;
    cyc("fwd_ab", 0, v, ex(0,0,0,0,0,0,2,1,0,0));
    v.fwe = 2'b01;
    cyc("fwd_we", 0, v, ex(0,0,0,0,0,0,0,1,0,0));

    // load-use
    v = '0; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8;
    cyc("lu_hit", 0, v, ex(1,1,0,0,1,0,0,0,0,0));
    v = '0;
    cyc("lu_after", 0, v, ex(0,0,0,0,0,0,0,0,0,0));
    v = '0; v.m2r_e = 1; v.rw_e = 1;
    cyc("lu_r0", 0, v, ex(0,0,0,0,0,0,0,0,0,0));
    v = '0; v.m2r_e = 1; v.wr_e = 8; v.rs_d = 8;
    cyc("lu_nowr", 0, v, ex(0,0,0,0,0,0,0,0,0,0));

    // MC_LAT=4, load-use present mid-op is ignored
    v = '0; v.mc = 1;
    cyc("mc4_c0", 0, v, ex(1,1,1,0,0,1,0,0,1,0));
    v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rt_d = 8;
    cyc("mc4_c1", 0, v, ex(1,1,1,0,0,1,0,0,1,0));
    v = '0; v.mc = 1;
    cyc("mc4_c2", 0, v, ex(1,1,1,0,0,1,0,0,1,0));
    cyc("mc4_done", 0, v, ex(0,0,0,0,0,0,0,0,0,1));
    v = '0;
    cyc("mc4_idle", 0, v, ex(0,0,0,0,0,0,0,0,0,0));

    // branch aborts op in cycle 1
    v = '0; v.mc = 1;
    cyc("br_c0", 0, v, ex(1,1,1,0,0,1,0,0,1,0));
    v.br = 1; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 8; v.rs_d = 8;
    cyc("br_c1", 0, v, ex(0,0,0,1,1,0,0,0,0,0));
    v = '0;
    cyc("br_c2", 0, v, ex(0,0,0,0,0,0,0,0,0,0));
    cyc("br_c3", 0, v, ex(0,0,0,0,0,0,0,0,0,0));

    // reset while busy
    v = '0; v.mc = 1;
    cyc("rb_c0", 0, v, ex(1,1,1,0,0,1,0,0,1,0));
    cyc("rb_c1", 0, v, ex(1,1,1,0,0,1,0,0,1,0));
    v.rst = 1;
    cyc("rb_rst", 0, v, ex(0,0,0,1,1,1,0,0,0,0));
    v = '0;
    cyc("rb_c3", 0, v, ex(0,0,0,0,0,0,0,0,0,0));
    cyc("rb_c4", 0, v, ex(0,0,0,0,0,0,0,0,0,0));

    // MC_LAT=2 back-to-back
    v = '0; v.mc = 1;
    cyc("mc2_a0", 1, v, ex(1,1,1,0,0,1,0,0,1,0));
    cyc("mc2_a1", 1, v, ex(0,0,0,0,0,0,0,0,0,1));
    cyc("mc2_b0", 1, v, ex(1,1,1,0,0,1,0,0,1,0));
    cyc("mc2_b1", 1, v, ex(0,0,0,0,0,0,0,0,0,1));
    v = '0;
    cyc("mc2_idle", 1, v, ex(0,0,0,0,0,0,0,0,0,0));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
